vga_color_sequencer: RTL and testbench
======================================

VGA_COLOR_SEQUENCER -- requirements
Module: vga_color_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the number of stable clk cycles needed to accept a button level.
REQ-002 SHALL have parameter FRAMES_PER_STEP, default 60, the number of frames per palette step in AUTO mode.
REQ-003 SHALL have port clk  input  1  pixel clock; the only clock.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_mode  input  1  raw mode button, asynchronous to clk.
REQ-006 SHALL have port btn_next  input  1  raw step button, asynchronous to clk.
REQ-007 SHALL have ports sw_red, sw_green, sw_blue  input  4 each  manual colour switches.
REQ-008 SHALL have port y_pixel  input  10  current line from the VGA timing generator.
REQ-009 SHALL have ports red, green, blue  output  4 each  registered colour to the RGB switch datapath.
REQ-010 SHALL have port mode  output  2  current state: 00 MANUAL, 01 AUTO, 10 STEP.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at the start of vertical blank.

Function
REQ-012 SHALL pass each button through a 2-flop synchroniser, then through a debouncer.
REQ-013 Debouncer SHALL accept a new level only after DEBOUNCE_CYCLES consecutive equal samples; any change restarts the count.
REQ-014 SHALL produce a one-cycle press pulse on each rising edge of a debounced level; holding a button SHALL yield exactly one pulse.
REQ-015 SHALL register y_pixel and assert frame_tick for one cycle when the previous y_pixel is 479 and the current y_pixel is 480.
REQ-016 FSM SHALL advance on each mode press: MANUAL -> AUTO -> STEP -> MANUAL; encoding 2'b11 SHALL be unreachable and SHALL recover to MANUAL on the next cycle.
REQ-017 SHALL hold a 3-bit palette index with this palette: 0 FFF, 1 FF0, 2 0FF, 3 0F0, 4 F0F, 5 F00, 6 00F, 7 000 (R,G,B hex nibbles).
REQ-018 red, green and blue SHALL change only in the cycle after frame_tick, never during active video.
REQ-019 MANUAL: on each frame_tick, SHALL load red/green/blue from sw_red/sw_green/sw_blue as sampled in the frame_tick cycle.
REQ-020 AUTO: SHALL count frame_ticks; on the FRAMES_PER_STEP-th tick, SHALL increment the index (7 wraps to 0), clear the count and load the palette entry; on other ticks it SHALL reload the current entry.
REQ-021 STEP: a next press SHALL set a pending flag; on frame_tick with pending set (including a press in the same cycle), SHALL increment the index once, clear pending and load the entry.
REQ-022 STEP: multiple presses within one frame SHALL collapse to a single step.
REQ-023 next presses outside STEP SHALL be ignored and SHALL NOT set pending.
REQ-024 A mode press and a next press in the same cycle: mode SHALL take priority and next SHALL be discarded.
REQ-025 Any mode change SHALL clear the frame counter and the pending flag; the palette index SHALL be preserved.
REQ-026 New mode colours SHALL appear at the next frame_tick.
REQ-027 Output latency SHALL be 1 clk from frame_tick to the updated red/green/blue.

Reset
REQ-028 reset_n low SHALL immediately force red, green, blue = 0, mode = MANUAL, frame_tick = 0, index = 0, and all counters, pending flags and synchroniser/debounce state to 0.
REQ-029 Reset asserted mid-debounce or mid-frame SHALL discard partial counts.
REQ-030 After reset release, outputs SHALL stay 0 until the first frame_tick.

Verification (DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=2)
REQ-031 Reset, MANUAL, sw=A/5/3, y_pixel 479->480 -> frame_tick pulses 1 cycle; next cycle red=A, green=5, blue=3; sw change mid-frame SHALL NOT alter outputs.
REQ-032 btn_mode bounces (1 for 2 cycles, 0, then 1 held 10 cycles) -> exactly one press; mode=01 after 4 stable cycles plus synchroniser delay.
REQ-033 AUTO, index 6, 4 frame_ticks -> index 7 (000) after tick 2; index 0 (FFF) after tick 4 (wrap).
REQ-034 STEP, three next presses in one frame -> index increments by exactly 1 at the next frame_tick; a press coincident with frame_tick steps at that tick.
REQ-035 Simultaneous mode and next presses in STEP -> mode=00 and index unchanged.
REQ-036 reset_n pulsed low during AUTO with count=1 -> outputs 0 asynchronously; mode=00; after release, the first two frames do not step the index.

Source files
------------

// File: rtl/vga_color_sequencer.sv
// vga_color_sequencer
//
// Picks the colour driven onto the RGB switch datapath once per frame.
// Three modes, cycled by the debounced mode button:
//   MANUAL (00) - colour taken from the switches at each frame start
//   AUTO   (01) - walks an 8-entry palette, one step every FRAMES_PER_STEP frames
//   STEP   (10) - walks the palette one entry per next-button press,
//                 applied at the following frame start
// Colours only change in the cycle after frame_tick, i.e. inside vertical
// blank, so a frame is never drawn with two different colours.
//
// Ports
//   clk        pixel clock (only clock)
//   reset_n    asynchronous active-low reset
//   btn_mode   raw mode button (asynchronous)
//   btn_next   raw step button (asynchronous)
//   sw_red/sw_green/sw_blue  manual colour switches, 4 bits each
//   y_pixel    current line from the VGA timing generator
//   red/green/blue  registered colour outputs, 4 bits each
//   mode       current FSM state (00 MANUAL, 01 AUTO, 10 STEP)
//   frame_tick one-cycle pulse on the 479 -> 480 line transition
module vga_color_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic [3:0] sw_red,
  input  logic [3:0] sw_green,
  input  logic [3:0] sw_blue,
  input  logic [9:0] y_pixel,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [1:0] mode,
  output logic       frame_tick
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(FRAMES_PER_STEP + 1);

  typedef enum logic [1:0] {
    S_MANUAL = 2'b00,
    S_AUTO   = 2'b01,
    S_STEP   = 2'b10
  } state_t;

  // Bit 0 is the mode button, bit 1 is the next button.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    press;
  logic [DW-1:0] dcnt [2];

  logic [9:0]    y_q;

  state_t        state;
  state_t        state_n;

  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_n;
  logic          pending;
  logic          pend_n;
  logic [11:0]   rgb;
  logic [11:0]   rgb_n;

  logic          mode_press;
  logic          next_press;

  function automatic logic [11:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    palette = 12'hFFF;
      3'd1:    palette = 12'hFF0;
      3'd2:    palette = 12'h0FF;
      3'd3:    palette = 12'h0F0;
      3'd4:    palette = 12'hF0F;
      3'd5:    palette = 12'hF00;
      3'd6:    palette = 12'h00F;
      default: palette = 12'h000;
    endcase
  endfunction

  // Synchroniser + debouncer. The counter runs only while the synchronised
  // sample disagrees with the accepted level; one agreeing sample (a bounce
  // back) restarts it. The press pulse is raised only on an accepted 0->1,
  // so a held button yields a single pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= {btn_next, btn_mode};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != db[i]) begin
          if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]    <= sync2[i];
            dcnt[i]  <= '0;
            press[i] <= sync2[i];
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  assign mode_press = press[0];
  assign next_press = press[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) y_q <= '0;
    else          y_q <= y_pixel;
  end

  assign frame_tick = (y_q == 10'd479) && (y_pixel == 10'd480);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_MANUAL;
    else          state <= state_n;
  end

  // FSM next state; the unused 2'b11 encoding falls back to MANUAL.
  always_comb begin
    state_n = state;
    case (state)
      S_MANUAL: if (mode_press) state_n = S_AUTO;
      S_AUTO:   if (mode_press) state_n = S_STEP;
      S_STEP:   if (mode_press) state_n = S_MANUAL;
      default:  state_n = S_MANUAL;
    endcase
  end

  assign mode = state;

  // Colour datapath. A next press only counts in STEP and loses to a
  // simultaneous mode press. A press in the frame_tick cycle is folded
  // into pend_n before the tick is evaluated so it steps at that tick.
  always_comb begin
    idx_n  = idx;
    fcnt_n = fcnt;
    pend_n = pending;
    rgb_n  = rgb;
    if (next_press && !mode_press && (state == S_STEP)) pend_n = 1'b1;
    if (frame_tick) begin
      case (state)
        S_MANUAL: rgb_n = {sw_red, sw_green, sw_blue};
        S_AUTO: begin
          if (fcnt == FW'(FRAMES_PER_STEP - 1)) begin
            idx_n  = idx + 3'd1;
            fcnt_n = '0;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
          rgb_n = palette(idx_n);
        end
        S_STEP: begin
          if (pend_n) begin
            idx_n  = idx + 3'd1;
            pend_n = 1'b0;
          end
          rgb_n = palette(idx_n);
        end
        default: rgb_n = rgb;
      endcase
    end
    // Entering a new mode starts it from a clean frame count with no
    // queued step; the palette index carries over.
    if (state_n != state) begin
      fcnt_n = '0;
      pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      fcnt    <= '0;
      pending <= 1'b0;
      rgb     <= '0;
    end else begin
      idx     <= idx_n;
      fcnt    <= fcnt_n;
      pending <= pend_n;
      rgb     <= rgb_n;
    end
  end

  assign red   = rgb[11:8];
  assign green = rgb[7:4];
  assign blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Directed bench for vga_color_sequencer with DEBOUNCE_CYCLES=4 and
// FRAMES_PER_STEP=2. Inputs change 1 ns after the rising edge, outputs are
// sampled there too (or 1 ns after a combinational input change).
module tb_vga_color_sequencer;

  logic       clk;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_next;
  logic [3:0] sw_red;
  logic [3:0] sw_green;
  logic [3:0] sw_blue;
  logic [9:0] y_pixel;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic [1:0] mode;
  logic       frame_tick;
  logic [11:0] rgb_obs;

  int checks = 0;
  int errors = 0;

  logic [11:0] pal [8];

  assign rgb_obs = {red, green, blue};

  vga_color_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_STEP(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .sw_red    (sw_red),
    .sw_green  (sw_green),
    .sw_blue   (sw_blue),
    .y_pixel   (y_pixel),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .mode      (mode),
    .frame_tick(frame_tick)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame boundary: line 479 for a cycle, then 480 (tick cycle), then
  // back into active video. Returns frame_tick as seen in the 480 cycle.
  task automatic do_frame(output logic ft);
    y_pixel = 10'd479;
    cyc(1);
    y_pixel = 10'd480;
    #1;
    ft = frame_tick;
    cyc(1);
    y_pixel = 10'd100;
    #1;
  endtask

  task automatic press(input logic m, input logic n);
    btn_mode = m;
    btn_next = n;
    cyc(8);
    btn_mode = 1'b0;
    btn_next = 1'b0;
    cyc(8);
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    btn_mode = 1'b0;
    btn_next = 1'b0;
    sw_red   = 4'h0;
    sw_green = 4'h0;
    sw_blue  = 4'h0;
    y_pixel  = 10'd0;
    cyc(3);
    checks++;
    if (rgb_obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got %h exp %h", rgb_obs, 12'h000);
    end
    checks++;
    if (mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_mode got %b exp %b", mode, 2'b00);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick got %b exp %b", frame_tick, 1'b0);
    end
    reset_n = 1'b1;
    y_pixel = 10'd100;
    cyc(3);
  endtask

  task automatic test_manual;
    logic ft;
    sw_red   = 4'hA;
    sw_green = 4'h5;
    sw_blue  = 4'h3;
    cyc(3);
    checks++;
    if (rgb_obs !== 12'h000) begin
      errors++;
      $display("FAIL manual_pre_tick got %h exp %h", rgb_obs, 12'h000);
    end
    y_pixel = 10'd479;
    cyc(1);
    y_pixel = 10'd480;
    #1;
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL manual_tick got %b exp %b", frame_tick, 1'b1);
    end
    checks++;
    if (rgb_obs !== 12'h000) begin
      errors++;
      $display("FAIL manual_tick_cycle_rgb got %h exp %h", rgb_obs, 12'h000);
    end
    cyc(1);
    y_pixel = 10'd481;
    #1;
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL manual_tick_width got %b exp %b", frame_tick, 1'b0);
    end
    checks++;
    if (rgb_obs !== 12'hA53) begin
      errors++;
      $display("FAIL manual_load got %h exp %h", rgb_obs, 12'hA53);
    end
    y_pixel  = 10'd100;
    sw_red   = 4'h1;
    sw_green = 4'h2;
    sw_blue  = 4'h4;
    cyc(5);
    checks++;
    if (rgb_obs !== 12'hA53) begin
      errors++;
      $display("FAIL manual_midframe got %h exp %h", rgb_obs, 12'hA53);
    end
    do_frame(ft);
    checks++;
    if (ft !== 1'b1 || rgb_obs !== 12'h124) begin
      errors++;
      $display("FAIL manual_second got tick %b rgb %h exp tick 1 rgb %h", ft, rgb_obs, 12'h124);
    end
  endtask

  // Bounce: 1 for two cycles, 0 for one, then 1 for ten. The stable run
  // starts at edge 4; through the 2-flop synchroniser and four counting
  // edges the level is accepted at edge 9 and the FSM moves at edge 10.
  task automatic test_debounce;
    logic [13:0] pat;
    logic [1:0]  hist [14];
    logic [1:0]  last;
    int          changes;
    pat = 14'b0_1111111111_0_11;
    for (int i = 0; i < 14; i++) begin
      btn_mode = pat[i];
      cyc(1);
      hist[i] = mode;
    end
    btn_mode = 1'b0;
    changes = 0;
    last = 2'b00;
    for (int i = 0; i < 14; i++) begin
      if (hist[i] != last) changes++;
      last = hist[i];
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (mode != last) changes++;
      last = mode;
    end
    checks++;
    if (hist[8] !== 2'b00) begin
      errors++;
      $display("FAIL debounce_early got %b exp %b", hist[8], 2'b00);
    end
    checks++;
    if (hist[9] !== 2'b01) begin
      errors++;
      $display("FAIL debounce_accept got %b exp %b", hist[9], 2'b01);
    end
    checks++;
    if (changes != 1 || mode !== 2'b01) begin
      errors++;
      $display("FAIL debounce_single got changes %0d mode %b exp changes 1 mode 01", changes, mode);
    end
  endtask

  // AUTO from index 0: tick t shows palette entry (t/2) mod 8, so ticks
  // 12..16 cover index 6 -> 7 -> wrap to 0.
  task automatic test_auto_wrap;
    logic        ft;
    logic [11:0] exp_rgb;
    for (int t = 1; t <= 16; t++) begin
      do_frame(ft);
      exp_rgb = pal[(t / 2) % 8];
      checks++;
      if (ft !== 1'b1 || rgb_obs !== exp_rgb) begin
        errors++;
        $display("FAIL auto_tick%0d got tick %b rgb %h exp tick 1 rgb %h", t, ft, rgb_obs, exp_rgb);
      end
    end
  endtask

  task automatic test_step;
    logic ft;
    press(1'b1, 1'b0);
    checks++;
    if (mode !== 2'b10) begin
      errors++;
      $display("FAIL step_mode got %b exp %b", mode, 2'b10);
    end
    do_frame(ft);
    checks++;
    if (rgb_obs !== 12'hFFF) begin
      errors++;
      $display("FAIL step_no_press got %h exp %h", rgb_obs, 12'hFFF);
    end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    checks++;
    if (rgb_obs !== 12'hFFF) begin
      errors++;
      $display("FAIL step_before_tick got %h exp %h", rgb_obs, 12'hFFF);
    end
    do_frame(ft);
    checks++;
    if (rgb_obs !== 12'hFF0) begin
      errors++;
      $display("FAIL step_collapse got %h exp %h", rgb_obs, 12'hFF0);
    end
    do_frame(ft);
    checks++;
    if (rgb_obs !== 12'hFF0) begin
      errors++;
      $display("FAIL step_idle_frame got %h exp %h", rgb_obs, 12'hFF0);
    end
    // Button raised after edge 0: pulse lands in the edge 6..7 cycle, which
    // is arranged to be the frame_tick cycle.
    btn_next = 1'b1;
    cyc(5);
    y_pixel = 10'd479;
    cyc(1);
    y_pixel = 10'd480;
    #1;
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL step_coincident_tick got %b exp %b", frame_tick, 1'b1);
    end
    cyc(1);
    y_pixel = 10'd100;
    #1;
    checks++;
    if (rgb_obs !== 12'h0FF) begin
      errors++;
      $display("FAIL step_coincident got %h exp %h", rgb_obs, 12'h0FF);
    end
    btn_next = 1'b0;
    cyc(8);
    do_frame(ft);
    checks++;
    if (rgb_obs !== 12'h0FF) begin
      errors++;
      $display("FAIL step_after_coincident got %h exp %h", rgb_obs, 12'h0FF);
    end
  endtask

  task automatic test_priority;
    logic ft;
    press(1'b1, 1'b1);
    checks++;
    if (mode !== 2'b00) begin
      errors++;
      $display("FAIL prio_mode got %b exp %b", mode, 2'b00);
    end
    press(1'b0, 1'b1);
    do_frame(ft);
    checks++;
    if (rgb_obs !== 12'h124) begin
      errors++;
      $display("FAIL prio_manual got %h exp %h", rgb_obs, 12'h124);
    end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    do_frame(ft);
    checks++;
    if (mode !== 2'b10 || rgb_obs !== 12'h0FF) begin
      errors++;
      $display("FAIL prio_index got mode %b rgb %h exp mode 10 rgb %h", mode, rgb_obs, 12'h0FF);
    end
  endtask

  task automatic test_reset_mid_auto;
    logic ft;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    do_frame(ft);
    checks++;
    if (mode !== 2'b01 || rgb_obs !== 12'h0FF) begin
      errors++;
      $display("FAIL rst_setup got mode %b rgb %h exp mode 01 rgb %h", mode, rgb_obs, 12'h0FF);
    end
    btn_mode = 1'b1;
    cyc(3);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rgb_obs !== 12'h000 || mode !== 2'b00 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got rgb %h mode %b tick %b exp rgb 000 mode 00 tick 0", rgb_obs, mode, frame_tick);
    end
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    btn_mode = 1'b0;
    cyc(8);
    checks++;
    if (rgb_obs !== 12'h000 || mode !== 2'b00) begin
      errors++;
      $display("FAIL rst_release got rgb %h mode %b exp rgb 000 mode 00", rgb_obs, mode);
    end
    do_frame(ft);
    checks++;
    if (rgb_obs !== 12'h124) begin
      errors++;
      $display("FAIL rst_frame1 got %h exp %h", rgb_obs, 12'h124);
    end
    press(1'b1, 1'b0);
    do_frame(ft);
    checks++;
    if (mode !== 2'b01 || rgb_obs !== 12'hFFF) begin
      errors++;
      $display("FAIL rst_auto1 got mode %b rgb %h exp mode 01 rgb %h", mode, rgb_obs, 12'hFFF);
    end
    do_frame(ft);
    checks++;
    if (rgb_obs !== 12'hFF0) begin
      errors++;
      $display("FAIL rst_auto2 got %h exp %h", rgb_obs, 12'hFF0);
    end
  endtask

  initial begin
    pal[0] = 12'hFFF;
    pal[1] = 12'hFF0;
    pal[2] = 12'h0FF;
    pal[3] = 12'h0F0;
    pal[4] = 12'hF0F;
    pal[5] = 12'hF00;
    pal[6] = 12'h00F;
    pal[7] = 12'h000;
    test_reset;
    test_manual;
    test_debounce;
    test_auto_wrap;
    test_step;
    test_priority;
    test_reset_mid_auto;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
